// File: rtl/pwm_duty_sched.sv
// Period-synchronous duty-cycle scheduler for the heater PWM generator.
// Derives a target on-time from (setpoint - temperature) * KP, or takes a
// manual override. Slews pwm_ton toward that target by at most STEP once
// per PWM period. Forces the heater off on over-temperature or when the
// temperature feed goes stale.
module pwm_duty_sched #(
    parameter int unsigned PERIOD       = 100000,
    parameter int unsigned STEP         = 1000,
    parameter int unsigned KP           = 256,
    parameter int unsigned WDOG_PERIODS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_en,
    input  logic        temp_valid,
    input  logic [15:0] temp,
    input  logic [15:0] setpoint,
    input  logic [15:0] ovt_limit,
    input  logic [15:0] hyst,
    input  logic        man_en,
    input  logic [31:0] man_ton,
    input  logic        fault_clr,
    input  logic [31:0] pwm_cnt,
    output logic        pwm_en,
    output logic [31:0] pwm_ton,
    output logic [31:0] pwm_tp,
    output logic [1:0]  state,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        at_target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    localparam int unsigned WW         = $clog2(WDOG_PERIODS + 1);
    localparam logic [31:0] TP         = 32'(PERIOD - 1);
    localparam logic [32:0] TP33       = {1'b0, TP};
    localparam logic [31:0] STEP32     = 32'(STEP);
    localparam logic [32:0] STEP33     = {1'b0, STEP32};
    localparam logic [32:0] KP33       = 33'(KP);
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_PERIODS);
    localparam logic [WW-1:0] WDOG_ONE = WW'(1);

    state_t         state_q, state_d;
    logic [31:0]    ton_d;
    logic [WW-1:0]  wdog_q, wdog_d;
    logic [1:0]     code_d;
    logic [15:0]    temp_q;

    logic signed [16:0] err;
    logic [32:0]        prod;
    logic [31:0]        target;
    logic [32:0]        up_sum;
    logic [31:0]        ramp;
    logic               boundary;
    logic               ovt_trip;
    logic               clr_ok;

    assign pwm_tp = TP;
    assign pwm_en = (state_q == S_RUN);
    assign state  = state_q;
    assign fault  = (state_q == S_FAULT);

    // Target on-time: proportional term from the latched temperature, clamped to the period, or the clamped manual value
    always_comb begin
        err    = $signed({1'b0, setpoint}) - $signed({1'b0, temp_q});
        prod   = {17'd0, err[15:0]} * KP33;
        target = 32'd0;
        if (man_en) begin
            target = (man_ton > TP) ? TP : man_ton;
        end else if (!err[16] && (err != 17'sd0)) begin
            target = (prod > TP33) ? TP : prod[31:0];
        end
    end

    // One bounded slew step toward the target; the down path compares before subtracting so it cannot wrap
    always_comb begin
        up_sum = {1'b0, pwm_ton} + STEP33;
        ramp   = pwm_ton;
        if (pwm_ton < target) begin
            ramp = (up_sum > {1'b0, target}) ? target : up_sum[31:0];
        end else if (pwm_ton > target) begin
            ramp = ((pwm_ton - target) > STEP32) ? (pwm_ton - STEP32) : target;
        end
    end

    // Next-state logic: over-temperature beats watchdog beats disable beats ramp
    always_comb begin
        boundary = pwm_en && (pwm_cnt == TP);
        ovt_trip = temp_valid && (temp >= ovt_limit);
        clr_ok   = fault_clr && (({1'b0, temp_q} + {1'b0, hyst}) < {1'b0, ovt_limit});
        state_d  = state_q;
        ton_d    = pwm_ton;
        wdog_d   = wdog_q;
        code_d   = fault_code;
        case (state_q)
            S_IDLE: begin
                ton_d = 32'd0;
                if (ovt_trip) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else if (ctrl_en) begin
                    state_d = S_RUN;
                    wdog_d  = '0;
                end
            end
            S_RUN: begin
                if (temp_valid) begin
                    wdog_d = '0;
                end else if (boundary) begin
                    wdog_d = wdog_q + WDOG_ONE;
                end
                if (ovt_trip) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                    ton_d   = 32'd0;
                end else if (wdog_d == WDOG_LIM) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                    ton_d   = 32'd0;
                end else if (!ctrl_en) begin
                    state_d = S_IDLE;
                    ton_d   = 32'd0;
                end else if (boundary) begin
                    ton_d = ramp;
                end
            end
            S_FAULT: begin
                ton_d = 32'd0;
                if (clr_ok) begin
                    state_d = S_IDLE;
                    code_d  = 2'b00;
                    wdog_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ton_d   = 32'd0;
                wdog_d  = '0;
                code_d  = 2'b00;
            end
        endcase
    end

    // Controller state register: state, on-time, watchdog count and sticky fault code
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pwm_ton    <= 32'd0;
            wdog_q     <= '0;
            fault_code <= 2'b00;
        end else begin
            state_q    <= state_d;
            pwm_ton    <= ton_d;
            wdog_q     <= wdog_d;
            fault_code <= code_d;
        end
    end

    // Latch each valid temperature sample and register the at-target flag
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_q    <= 16'd0;
            at_target <= 1'b0;
        end else begin
            if (temp_valid) begin
                temp_q <= temp;
            end
            at_target <= (state_q == S_RUN) && (pwm_ton == target);
        end
    end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard testbench for pwm_duty_sched: the driver applies one cycle of
// stimulus at each falling edge, steps a behavioural model and queues the
// expected post-edge outputs; the monitor pops and compares after each rising edge.
module tb_pwm_duty_sched;

    localparam int P    = 100;
    localparam int STEP = 10;
    localparam int KP   = 4;
    localparam int W    = 3;

    logic        clk = 1'b0;
    logic        rst, ctrl_en, temp_valid, man_en, fault_clr;
    logic [15:0] temp, setpoint, ovt_limit, hyst;
    logic [31:0] man_ton, pwm_cnt;
    logic        pwm_en, fault, at_target;
    logic [31:0] pwm_ton, pwm_tp;
    logic [1:0]  state, fault_code;

    typedef struct {
        int     st;
        int     en;
        longint ton;
        int     flt;
        int     code;
        int     at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // stimulus state
    bit     s_rst = 1, s_ctrl = 0, s_tv = 0, s_man = 0, s_clr = 0;
    int     s_temp = 0, s_set = 50, s_ovt = 80, s_hyst = 10;
    longint s_man_ton = 0;
    int     cnt_r = 0;
    bit     auto_feed = 0;
    int     feed_temp = 0;
    int     cyc = 0;

    // model state
    int     m_st = 0;
    longint m_ton = 0;
    int     m_tq = 0;
    int     m_miss = 0;
    int     m_code = 0;
    int     m_at = 0;

    always #5 clk = ~clk;

    pwm_duty_sched #(
        .PERIOD(P), .STEP(STEP), .KP(KP), .WDOG_PERIODS(W)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .temp_valid(temp_valid),
        .temp(temp), .setpoint(setpoint), .ovt_limit(ovt_limit), .hyst(hyst),
        .man_en(man_en), .man_ton(man_ton), .fault_clr(fault_clr), .pwm_cnt(pwm_cnt),
        .pwm_en(pwm_en), .pwm_ton(pwm_ton), .pwm_tp(pwm_tp), .state(state),
        .fault(fault), .fault_code(fault_code), .at_target(at_target)
    );

    function automatic longint model_target();
        longint t;
        if (s_man) t = s_man_ton;
        else if (s_set > m_tq) t = longint'(s_set - m_tq) * KP;
        else t = 0;
        if (t > P - 1) t = P - 1;
        return t;
    endfunction

    task automatic modelStep();
        bit     boundary, ovt;
        longint tgt;
        int     at_n, n_tq;
        exp_t   e;
        boundary = (m_st == 1) && (cnt_r == P - 1);
        tgt      = model_target();
        ovt      = s_tv && (s_temp >= s_ovt);
        at_n     = ((m_st == 1) && (m_ton == tgt)) ? 1 : 0;
        if (s_rst) begin
            m_st = 0; m_ton = 0; m_tq = 0; m_miss = 0; m_code = 0; m_at = 0;
        end else begin
            n_tq = s_tv ? s_temp : m_tq;
            case (m_st)
                0: begin
                    if (ovt) begin m_st = 2; m_code = 1; end
                    else if (s_ctrl) begin m_st = 1; m_ton = 0; m_miss = 0; end
                end
                1: begin
                    if (s_tv) m_miss = 0;
                    else if (boundary) m_miss++;
                    if (ovt) begin m_st = 2; m_code = 1; m_ton = 0; end
                    else if (m_miss >= W) begin m_st = 2; m_code = 2; m_ton = 0; end
                    else if (!s_ctrl) begin m_st = 0; m_ton = 0; end
                    else if (boundary) begin
                        if (m_ton < tgt) m_ton = (m_ton + STEP < tgt) ? m_ton + STEP : tgt;
                        else if (m_ton > tgt) m_ton = (m_ton - STEP > tgt) ? m_ton - STEP : tgt;
                    end
                end
                default: begin
                    if (s_clr && (m_tq + s_hyst < s_ovt)) begin
                        m_st = 0; m_code = 0; m_miss = 0;
                    end
                end
            endcase
            m_tq = n_tq;
            m_at = at_n;
        end
        e.st   = m_st;
        e.en   = (m_st == 1) ? 1 : 0;
        e.ton  = m_ton;
        e.flt  = (m_st == 2) ? 1 : 0;
        e.code = m_code;
        e.at   = m_at;
        exp_q.push_back(e);
    endtask

    // one clock of stimulus: drive, model, queue expectation, clear strobes
    task automatic applyStimulus();
        @(negedge clk);
        if (auto_feed && !s_tv && (cyc % 50 == 0)) begin
            s_tv   = 1;
            s_temp = feed_temp;
        end
        rst        = s_rst;
        ctrl_en    = s_ctrl;
        temp_valid = s_tv;
        temp       = 16'(s_temp);
        setpoint   = 16'(s_set);
        ovt_limit  = 16'(s_ovt);
        hyst       = 16'(s_hyst);
        man_en     = s_man;
        man_ton    = 32'(s_man_ton);
        fault_clr  = s_clr;
        pwm_cnt    = 32'(cnt_r);
        modelStep();
        cnt_r = (cnt_r + 1) % P;
        cyc++;
        s_tv  = 0;
        s_clr = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic alignBoundary();
        while (cnt_r != P - 1) applyStimulus();
    endtask

    task automatic cmp(input string name, input logic [32:0] act, input logic [32:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("state", 33'(state), 33'(e.st));
        cmp("pwm_en", 33'(pwm_en), 33'(e.en));
        cmp("pwm_ton", 33'(pwm_ton), 33'(e.ton));
        cmp("fault", 33'(fault), 33'(e.flt));
        cmp("fault_code", 33'(fault_code), 33'(e.code));
        cmp("at_target", 33'(at_target), 33'(e.at));
        cmp("pwm_tp", 33'(pwm_tp), 33'(P - 1));
    endtask

    // monitor: compare DUT outputs shortly after each rising edge
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // watchdog on the whole run
    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1; ctrl_en = 0; temp_valid = 0; temp = 0; setpoint = 0; ovt_limit = 0;
        hyst = 0; man_en = 0; man_ton = 0; fault_clr = 0; pwm_cnt = 0;

        // reset
        s_rst = 1;
        tick(2);
        s_rst = 0;

        // ramp up to target 40
        s_set = 50; s_ovt = 80; s_hyst = 10;
        feed_temp = 40; auto_feed = 1; s_ctrl = 1;
        tick(600);

        // clamp to 99, then ramp down to 4
        feed_temp = 0;
        tick(1200);
        feed_temp = 49;
        tick(1200);

        // over-temperature trip and fault exit
        feed_temp = 40;
        tick(800);
        auto_feed = 0;
        s_tv = 1; s_temp = 85;
        applyStimulus();
        tick(5);
        s_tv = 1; s_temp = 75;
        applyStimulus();
        s_clr = 1;
        applyStimulus();
        tick(3);
        s_hyst = 16'hFFF0;
        s_tv = 1; s_temp = 60;
        applyStimulus();
        s_clr = 1;
        applyStimulus();
        tick(2);
        s_hyst = 10;
        s_clr = 1;
        applyStimulus();
        tick(3);

        // watchdog trip on stale feed
        tick(400);
        s_clr = 1;
        applyStimulus();
        tick(3);
        alignBoundary();
        applyStimulus();
        alignBoundary();
        s_tv = 1; s_temp = 60;
        applyStimulus();
        tick(150);

        // manual override then back to proportional
        auto_feed = 1; feed_temp = 40;
        s_man = 1; s_man_ton = 500;
        tick(1200);
        s_man = 0;
        tick(800);

        // reset mid-ramp, and disable in RUN
        feed_temp = 0;
        tick(250);
        s_rst = 1;
        applyStimulus();
        s_rst = 0;
        tick(300);
        s_ctrl = 0;
        applyStimulus();
        tick(3);
        s_ctrl = 1;

        // randomized phase
        auto_feed = 0;
        for (int i = 0; i < 3000; i++) begin
            s_rst  = ($urandom_range(0, 599) == 0);
            s_ctrl = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 24) == 0) begin
                s_tv   = 1;
                s_temp = int'($urandom_range(0, 95));
            end
            if ($urandom_range(0, 99) == 0) s_set = int'($urandom_range(20, 75));
            if ($urandom_range(0, 149) == 0) s_ovt = int'($urandom_range(70, 95));
            if ($urandom_range(0, 99) == 0) s_hyst = int'($urandom_range(0, 20));
            if ($urandom_range(0, 299) == 0) s_man = ~s_man;
            if ($urandom_range(0, 99) == 0) s_man_ton = longint'($urandom_range(0, 150));
            s_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 79) == 0) cnt_r = int'($urandom_range(0, P - 1));
            applyStimulus();
        end
        s_rst = 0;

        // drain scoreboard
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sched.md
Name: pwm_duty_sched

Overview:
- Period-synchronous duty-cycle controller that drives the En/Ton/Tp inputs of the heater PWM generator.
- Computes a target on-time from setpoint minus measured temperature (proportional term), or takes a manual override.
- Slews Ton toward the target by a bounded step once per PWM period.
- Forces the heater off on over-temperature or a stale temperature feed (watchdog).

Parameters:
- PERIOD, 100000: clock cycles per PWM period. Tp output = PERIOD-1.
- STEP, 1000: maximum Ton change per period, in clock cycles.
- KP, 256: proportional gain, in clock cycles of on-time per temperature LSB.
- WDOG_PERIODS, 16: number of consecutive periods without temp_valid that triggers a watchdog fault.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ctrl_en  in  1  level; enable closed-loop heating
- temp_valid  in  1  one-cycle strobe; temp is valid
- temp  in  16  measured temperature, unsigned LSB units
- setpoint  in  16  target temperature, unsigned
- ovt_limit  in  16  over-temperature trip level
- hyst  in  16  fault-clear hysteresis
- man_en  in  1  level; manual override of the target
- man_ton  in  32  manual on-time, cycles
- fault_clr  in  1  one-cycle strobe; request fault exit
- pwm_cnt  in  32  period counter fed back from the PWM generator (its cnt_val)
- pwm_en  out  1  PWM enable
- pwm_ton  out  32  PWM on-time
- pwm_tp  out  32  PWM period terminal count, constant PERIOD-1
- state  out  2  00 IDLE, 01 RUN, 10 FAULT
- fault  out  1  high while in FAULT
- fault_code  out  2  01 over-temperature, 10 watchdog; sticky until FAULT exit
- at_target  out  1  high in RUN when pwm_ton == target

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE, pwm_en=0, pwm_ton=0, temp_q=0, wdog=0, fault=0, fault_code=00, at_target=0.
  - pwm_tp is constant PERIOD-1 at all times.
  - rst asserted mid-RUN or mid-FAULT drops pwm_en on the same edge.
- temp_q register:
  - Loads temp on every cycle with temp_valid=1, in all states.
  - All decisions in a given cycle use temp_q before that edge's update, except the over-temperature check, which uses the live temp when temp_valid=1.
- Boundary event: boundary = pwm_en & (pwm_cnt == PERIOD-1).
- Target computation (combinational, from temp_q):
  - err = setpoint - temp_q, 17-bit signed.
  - err <= 0 -> target = 0.
  - Otherwise prod = err*KP, 33-bit unsigned; target = min(prod, PERIOD-1).
  - man_en=1 -> target = min(man_ton, PERIOD-1).
- IDLE:
  - pwm_en=0, pwm_ton=0.
  - ctrl_en=1 -> RUN next edge: pwm_en=1, pwm_ton=0, wdog=0.
- RUN:
  - pwm_en=1.
  - On a boundary edge:
    - pwm_ton < target -> pwm_ton = min(pwm_ton+STEP, target).
    - pwm_ton > target -> pwm_ton = max(pwm_ton-STEP, target). No underflow: compare before subtracting.
    - The new Ton is visible from the first cycle of the next period.
  - pwm_ton never changes except on a boundary edge.
  - ctrl_en=0 -> IDLE next edge: pwm_en=0, pwm_ton=0. No ramp-down.
- Watchdog (RUN only):
  - wdog increments on each boundary.
  - temp_valid clears wdog; if temp_valid and a boundary coincide, the clear wins.
  - wdog reaching WDOG_PERIODS -> FAULT, fault_code=10.
- Over-temperature:
  - temp_valid=1 with temp >= ovt_limit, in IDLE or RUN -> FAULT next edge, fault_code=01.
  - pwm_en=0 and pwm_ton=0 on that same edge.
- FAULT:
  - pwm_en=0, pwm_ton=0, fault=1.
  - Exit to IDLE only when fault_clr=1 and temp_q + hyst < ovt_limit; use a 17-bit compare, no wrap.
  - A fault_clr that does not meet this condition is ignored (not remembered).
  - On exit: fault_code=00, wdog=0.
  - A new trip while in FAULT does not change fault_code.
- Priority within a cycle: rst > over-temperature > watchdog > ctrl_en=0 > ramp.
  - Over-temperature and watchdog in the same cycle -> fault_code=01.
- at_target = (state==RUN) & (pwm_ton == target), registered.

Test Plan (PERIOD=100, STEP=10, KP=4, WDOG_PERIODS=3):
- Ramp up: rst, then ctrl_en=1, setpoint=50, one temp_valid with temp=40 (target=40) -> pwm_ton goes 10, 20, 30, 40 at successive pwm_cnt==99 edges; at_target=1 after the 4th; pwm_ton is stable between boundaries.
- Clamp and ramp down: temp=0 (prod=200) -> target clamps to 99, pwm_ton rises to 99; then temp=49 (target=4) -> pwm_ton goes 89, 79, …, 9, 4.
- Over-temperature: in RUN with pwm_ton=40, ovt_limit=80, temp_valid with temp=85 -> next edge state=10, pwm_en=0, pwm_ton=0, fault_code=01. fault_clr with temp_q=75, hyst=10 -> ignored. Feed temp=60, then fault_clr -> IDLE, fault_code=00.
- Watchdog: RUN with no temp_valid for 3 boundaries -> FAULT, fault_code=10. Repeat with temp_valid on the same cycle as the 2nd boundary -> no fault.
- Manual override: man_en=1, man_ton=500 -> target=99. Drop man_en -> slews back to the proportional target at 10 per period.
- Reset and enable: rst mid-ramp -> pwm_en=0, pwm_ton=0, state=IDLE same edge. ctrl_en=0 in RUN -> IDLE next edge.
